// File: rtl/ahb_sram_ctrl.sv
// AHB5 slave in front of a single-port synchronous SRAM with one-cycle read latency.
// It adds optional wait states, byte lanes, a two-cycle ERROR response and pipelined transfers.
module ahb_sram_ctrl #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_STATES = 0,
    parameter bit USE_HWSTRB  = 1'b1,
    localparam int NB  = DATA_WIDTH / 8,
    localparam int MAW = $clog2(MEM_DEPTH)
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    input  logic                  hsel,
    input  logic                  hready,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic [1:0]            htrans,
    input  logic                  hwrite,
    input  logic [2:0]            hsize,
    input  logic [DATA_WIDTH-1:0] hwdata,
    input  logic [NB-1:0]         hwstrb,
    output logic [DATA_WIDTH-1:0] hrdata,
    output logic                  hreadyout,
    output logic                  hresp,
    output logic                  hexokay,
    output logic                  mem_ce,
    output logic                  mem_we,
    output logic [MAW-1:0]        mem_addr,
    output logic [NB-1:0]         mem_be,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int C_NBL  = $clog2(NB);
    localparam int C_OFFW = (C_NBL > 0) ? C_NBL : 1;
    localparam int C_AW   = C_NBL + MAW;
    localparam logic [ADDR_WIDTH:0] C_LIMIT   = (ADDR_WIDTH + 1)'(MEM_DEPTH * NB);
    localparam logic [3:0]          C_WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_WR, S_RD0, S_RD1, S_ERR1, S_ERR2
    } state_t;

    state_t                r_state;
    logic                  r_hreadyout;
    logic                  r_hresp;
    logic                  r_hwrite;
    logic [2:0]            r_hsize;
    logic [3:0]            r_cnt;
    logic [C_AW-1:0]       r_haddr;
    logic [DATA_WIDTH-1:0] r_hrdata;

    logic                  w_accept;
    logic                  w_take;
    logic                  w_err;
    logic [6:0]            w_align_mask;
    logic [NB-1:0]         w_size_mask;
    logic [NB-1:0]         w_lane;
    logic [C_OFFW-1:0]     w_off;
    logic                  w_mem_ce;
    state_t                w_nxt;

    // BUSY (2'b01) is deliberately not an accept; only NONSEQ/SEQ start a transfer.
    assign w_accept = hsel & hready & ((htrans == 2'b10) | (htrans == 2'b11));
    assign w_take   = w_accept & (r_state inside {S_IDLE, S_WR, S_RD1, S_ERR2});

    assign w_align_mask = (7'd1 << hsize) - 7'd1;
    assign w_err = ({1'b0, haddr} >= C_LIMIT)
                 | (|(haddr[6:0] & w_align_mask))
                 | (hsize > 3'(C_NBL));

    always_comb begin
        w_nxt = S_IDLE;
        if (w_err)                w_nxt = S_ERR1;
        else if (WAIT_STATES > 0) w_nxt = S_WAIT;
        else if (hwrite)          w_nxt = S_WR;
        else                      w_nxt = S_RD0;
    end

    generate
        if (C_NBL > 0) begin : g_off
            assign w_off = r_haddr[C_OFFW-1:0];
        end else begin : g_no_off
            assign w_off = '0;
        end
    endgenerate

    always_comb begin
        w_size_mask = '0;
        for (int i = 0; i < NB; i++) begin
            w_size_mask[i] = (i < (1 << r_hsize));
        end
    end

    assign w_lane   = w_size_mask << w_off;
    assign w_mem_ce = (r_state == S_WR) | (r_state == S_RD0);

    always_comb begin
        mem_be = '0;
        if (w_mem_ce) begin
            if ((r_state == S_WR) && USE_HWSTRB) mem_be = w_lane & hwstrb;
            else                                 mem_be = w_lane;
        end
    end

    assign mem_ce    = w_mem_ce;
    assign mem_we    = (r_state == S_WR);
    assign mem_addr  = w_mem_ce ? r_haddr[C_NBL +: MAW] : '0;
    assign mem_wdata = hwdata;
    assign hreadyout = r_hreadyout;
    assign hresp     = r_hresp;
    assign hexokay   = 1'b0;
    // SRAM output is live in RD1; the register holds it for later data phases.
    assign hrdata    = (r_state == S_RD1) ? mem_rdata : r_hrdata;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_state     <= S_IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
            r_hwrite    <= 1'b0;
            r_hsize     <= '0;
            r_cnt       <= '0;
            r_haddr     <= '0;
            r_hrdata    <= '0;
        end else begin
            if (r_state == S_RD1) r_hrdata <= mem_rdata;
            case (r_state)
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state     <= r_hwrite ? S_WR : S_RD0;
                        r_hreadyout <= r_hwrite;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RD0: begin
                    r_state     <= S_RD1;
                    r_hreadyout <= 1'b1;
                end
                S_ERR1: begin
                    r_state     <= S_ERR2;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= 1'b1;
                end
                default: begin
                    if (w_take) begin
                        r_state     <= w_nxt;
                        r_hreadyout <= (w_nxt == S_WR);
                        r_hresp     <= (w_nxt == S_ERR1);
                        r_cnt       <= C_WS_LOAD;
                        r_haddr     <= haddr[C_AW-1:0];
                        r_hwrite    <= hwrite;
                        r_hsize     <= hsize;
                    end else begin
                        r_state     <= S_IDLE;
                        r_hreadyout <= 1'b1;
                        r_hresp     <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// Directed bench for ahb_sram_ctrl: a zero-wait instance and a three-wait instance,
// each backed by a behavioural synchronous SRAM.
module tb_ahb_sram_ctrl;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NB = 4;
    localparam int MAW = 10;

    logic hclk = 1'b0;
    always #5 hclk = ~hclk;

    logic          hresetn, hsel0, hsel1, hready_en, hwrite;
    logic [AW-1:0] haddr;
    logic [1:0]    htrans;
    logic [2:0]    hsize;
    logic [DW-1:0] hwdata;
    logic [NB-1:0] hwstrb;
    logic          hready0, hready1;

    logic [DW-1:0]  hrdata0, mem_wdata0, mem_rdata0, hrdata1, mem_wdata1, mem_rdata1;
    logic           hreadyout0, hresp0, hexokay0, mem_ce0, mem_we0;
    logic           hreadyout1, hresp1, hexokay1, mem_ce1, mem_we1;
    logic [MAW-1:0] mem_addr0, mem_addr1;
    logic [NB-1:0]  mem_be0, mem_be1;

    logic [DW-1:0] mem0 [0:1023];
    logic [DW-1:0] mem1 [0:1023];
    int ce_cnt1 = 0;
    int n_tests = 0;
    int n_fail = 0;

    assign hready0 = hreadyout0 & hready_en;
    assign hready1 = hreadyout1 & hready_en;

    ahb_sram_ctrl #(.WAIT_STATES(0)) u_dut0 (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel0), .hready(hready0), .haddr(haddr),
        .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hwstrb(hwstrb),
        .hrdata(hrdata0), .hreadyout(hreadyout0), .hresp(hresp0), .hexokay(hexokay0),
        .mem_ce(mem_ce0), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_be(mem_be0),
        .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0)
    );

    ahb_sram_ctrl #(.WAIT_STATES(3)) u_dut1 (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel1), .hready(hready1), .haddr(haddr),
        .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hwstrb(hwstrb),
        .hrdata(hrdata1), .hreadyout(hreadyout1), .hresp(hresp1), .hexokay(hexokay1),
        .mem_ce(mem_ce1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_be(mem_be1),
        .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
    );

    always @(posedge hclk) begin
        if (mem_ce0) begin
            if (mem_we0) begin
                for (int b = 0; b < NB; b++)
                    if (mem_be0[b]) mem0[mem_addr0][8*b +: 8] <= mem_wdata0[8*b +: 8];
            end else begin
                mem_rdata0 <= mem0[mem_addr0];
            end
        end
    end

    always @(posedge hclk) begin
        if (mem_ce1) begin
            ce_cnt1 <= ce_cnt1 + 1;
            if (mem_we1) begin
                for (int b = 0; b < NB; b++)
                    if (mem_be1[b]) mem1[mem_addr1][8*b +: 8] <= mem_wdata1[8*b +: 8];
            end else begin
                mem_rdata1 <= mem1[mem_addr1];
            end
        end
    end

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic bus_idle();
        hsel0 = 1'b0; hsel1 = 1'b0; htrans = 2'b00; hwrite = 1'b0; haddr = '0; hsize = 3'd0;
    endtask

    task automatic addr_phase(input logic s0, input logic s1, input logic w,
                              input logic [2:0] sz, input logic [AW-1:0] a);
        hsel0 = s0; hsel1 = s1; htrans = 2'b10; hwrite = w; hsize = sz; haddr = a;
    endtask

    task automatic test_reset();
        @(negedge hclk);
        n_tests++; if (hreadyout0 !== 1'b1) begin n_fail++; $display("FAIL rst_ro0: got %0h want 1", hreadyout0); end
        n_tests++; if (hresp0 !== 1'b0) begin n_fail++; $display("FAIL rst_resp0: got %0h want 0", hresp0); end
        n_tests++; if (hrdata0 !== 32'h0) begin n_fail++; $display("FAIL rst_hrdata0: got %h want 0", hrdata0); end
        n_tests++; if ({mem_ce0, mem_we0} !== 2'b00) begin n_fail++; $display("FAIL rst_ce_we0: got %b want 00", {mem_ce0, mem_we0}); end
        n_tests++; if (mem_be0 !== 4'h0) begin n_fail++; $display("FAIL rst_be0: got %h want 0", mem_be0); end
        n_tests++; if (mem_addr0 !== 10'h0) begin n_fail++; $display("FAIL rst_addr0: got %h want 0", mem_addr0); end
        n_tests++; if (hexokay0 !== 1'b0) begin n_fail++; $display("FAIL rst_exokay0: got %0h want 0", hexokay0); end
        n_tests++; if (hreadyout1 !== 1'b1) begin n_fail++; $display("FAIL rst_ro1: got %0h want 1", hreadyout1); end
        tick();
        hresetn = 1'b1;
    endtask

    task automatic test_write_read();
        addr_phase(1'b1, 1'b0, 1'b1, 3'd2, 32'h10);
        tick();
        bus_idle(); hwdata = 32'hDEADBEEF; hwstrb = 4'hF;
        @(negedge hclk);
        n_tests++; if ({mem_ce0, mem_we0} !== 2'b11) begin n_fail++; $display("FAIL w32_ce_we: got %b want 11", {mem_ce0, mem_we0}); end
        n_tests++; if (mem_be0 !== 4'hF) begin n_fail++; $display("FAIL w32_be: got %h want f", mem_be0); end
        n_tests++; if (mem_addr0 !== 10'd4) begin n_fail++; $display("FAIL w32_addr: got %0d want 4", mem_addr0); end
        n_tests++; if (mem_wdata0 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL w32_wdata: got %h want deadbeef", mem_wdata0); end
        n_tests++; if (hreadyout0 !== 1'b1) begin n_fail++; $display("FAIL w32_ro: got %0h want 1", hreadyout0); end
        tick();
        addr_phase(1'b1, 1'b0, 1'b0, 3'd2, 32'h10);
        tick();
        bus_idle();
        @(negedge hclk);
        n_tests++; if (hreadyout0 !== 1'b0) begin n_fail++; $display("FAIL r32_rd0_ro: got %0h want 0", hreadyout0); end
        n_tests++; if ({mem_ce0, mem_we0} !== 2'b10) begin n_fail++; $display("FAIL r32_rd0_ce_we: got %b want 10", {mem_ce0, mem_we0}); end
        n_tests++; if (mem_addr0 !== 10'd4) begin n_fail++; $display("FAIL r32_addr: got %0d want 4", mem_addr0); end
        tick();
        @(negedge hclk);
        n_tests++; if (hreadyout0 !== 1'b1 || hresp0 !== 1'b0) begin n_fail++; $display("FAIL r32_rd1_ro_resp: got %b want 10", {hreadyout0, hresp0}); end
        n_tests++; if (hrdata0 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL r32_data: got %h want deadbeef", hrdata0); end
        tick();
        @(negedge hclk);
        n_tests++; if (hrdata0 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL r32_hold: got %h want deadbeef", hrdata0); end
        n_tests++; if (mem_ce0 !== 1'b0 || mem_addr0 !== 10'd0) begin n_fail++; $display("FAIL idle_ce_addr: got %b/%h want 0/0", mem_ce0, mem_addr0); end
    endtask

    task automatic test_byte_lanes();
        addr_phase(1'b1, 1'b0, 1'b1, 3'd0, 32'h13);
        tick();
        bus_idle(); hwdata = 32'hAB000000; hwstrb = 4'h8;
        @(negedge hclk);
        n_tests++; if (mem_be0 !== 4'h8) begin n_fail++; $display("FAIL b_be: got %h want 8", mem_be0); end
        n_tests++; if (mem_addr0 !== 10'd4) begin n_fail++; $display("FAIL b_addr: got %0d want 4", mem_addr0); end
        tick();
        addr_phase(1'b1, 1'b0, 1'b1, 3'd0, 32'h13);
        tick();
        bus_idle(); hwdata = 32'h55000000; hwstrb = 4'h0;
        @(negedge hclk);
        n_tests++; if (mem_be0 !== 4'h0 || mem_ce0 !== 1'b1) begin n_fail++; $display("FAIL b_strb0: got be %h ce %b want 0/1", mem_be0, mem_ce0); end
        tick();
        addr_phase(1'b1, 1'b0, 1'b0, 3'd2, 32'h10);
        tick();
        bus_idle();
        tick();
        @(negedge hclk);
        n_tests++; if (hrdata0 !== 32'hABADBEEF) begin n_fail++; $display("FAIL b_readback: got %h want abadbeef", hrdata0); end
        tick();
        addr_phase(1'b1, 1'b0, 1'b1, 3'd1, 32'h12);
        tick();
        bus_idle(); hwdata = 32'h12340000; hwstrb = 4'hF;
        @(negedge hclk);
        n_tests++; if (mem_be0 !== 4'hC) begin n_fail++; $display("FAIL h_be: got %h want c", mem_be0); end
        tick();
    endtask

    task automatic test_errors();
        addr_phase(1'b1, 1'b0, 1'b0, 3'd2, 32'h1000);
        tick();
        bus_idle();
        @(negedge hclk);
        n_tests++; if ({hreadyout0, hresp0, mem_ce0} !== 3'b010) begin n_fail++; $display("FAIL oor_err1: got ro/rsp/ce %b want 010", {hreadyout0, hresp0, mem_ce0}); end
        tick();
        @(negedge hclk);
        n_tests++; if ({hreadyout0, hresp0, mem_ce0} !== 3'b110) begin n_fail++; $display("FAIL oor_err2: got ro/rsp/ce %b want 110", {hreadyout0, hresp0, mem_ce0}); end
        tick();
        @(negedge hclk);
        n_tests++; if ({hreadyout0, hresp0} !== 2'b10) begin n_fail++; $display("FAIL oor_after: got ro/rsp %b want 10", {hreadyout0, hresp0}); end
        addr_phase(1'b1, 1'b0, 1'b1, 3'd2, 32'h2);
        tick();
        bus_idle(); hwdata = 32'h0BADF00D; hwstrb = 4'hF;
        @(negedge hclk);
        n_tests++; if ({hreadyout0, hresp0, mem_ce0} !== 3'b010) begin n_fail++; $display("FAIL mis_err1: got ro/rsp/ce %b want 010", {hreadyout0, hresp0, mem_ce0}); end
        tick();
        @(negedge hclk);
        n_tests++; if ({hreadyout0, hresp0, mem_ce0, mem_we0} !== 4'b1100) begin n_fail++; $display("FAIL mis_err2: got ro/rsp/ce/we %b want 1100", {hreadyout0, hresp0, mem_ce0, mem_we0}); end
        tick();
        addr_phase(1'b1, 1'b0, 1'b0, 3'd3, 32'h0);
        tick();
        bus_idle();
        @(negedge hclk);
        n_tests++; if ({hresp0, mem_ce0} !== 2'b10) begin n_fail++; $display("FAIL size_err: got rsp/ce %b want 10", {hresp0, mem_ce0}); end
        tick();
        tick();
        addr_phase(1'b1, 1'b0, 1'b1, 3'd2, 32'hFFC);
        tick();
        bus_idle(); hwdata = 32'hA5A5A5A5; hwstrb = 4'hF;
        @(negedge hclk);
        n_tests++; if ({hresp0, mem_ce0} !== 2'b01 || mem_addr0 !== 10'h3FF) begin n_fail++; $display("FAIL top_word: got rsp/ce %b addr %h want 01/3ff", {hresp0, mem_ce0}, mem_addr0); end
        tick();
    endtask

    task automatic test_back_to_back();
        addr_phase(1'b1, 1'b0, 1'b1, 3'd2, 32'h40);
        tick();
        addr_phase(1'b1, 1'b0, 1'b1, 3'd2, 32'h44); hwdata = 32'h11111111; hwstrb = 4'hF;
        @(negedge hclk);
        n_tests++; if ({hreadyout0, mem_ce0, mem_we0} !== 3'b111 || mem_addr0 !== 10'h10) begin n_fail++; $display("FAIL b2b_w1: got ro/ce/we %b addr %h want 111/010", {hreadyout0, mem_ce0, mem_we0}, mem_addr0); end
        tick();
        addr_phase(1'b1, 1'b0, 1'b0, 3'd2, 32'h40); hwdata = 32'h22222222;
        @(negedge hclk);
        n_tests++; if ({hreadyout0, mem_ce0, mem_we0} !== 3'b111 || mem_addr0 !== 10'h11) begin n_fail++; $display("FAIL b2b_w2: got ro/ce/we %b addr %h want 111/011", {hreadyout0, mem_ce0, mem_we0}, mem_addr0); end
        n_tests++; if (mem_wdata0 !== 32'h22222222) begin n_fail++; $display("FAIL b2b_w2_data: got %h want 22222222", mem_wdata0); end
        tick();
        bus_idle();
        @(negedge hclk);
        n_tests++; if ({hreadyout0, mem_ce0, mem_we0} !== 3'b010 || mem_addr0 !== 10'h10) begin n_fail++; $display("FAIL b2b_rd0: got ro/ce/we %b addr %h want 010/010", {hreadyout0, mem_ce0, mem_we0}, mem_addr0); end
        tick();
        @(negedge hclk);
        n_tests++; if (hreadyout0 !== 1'b1 || hrdata0 !== 32'h11111111) begin n_fail++; $display("FAIL b2b_rd1: got ro %b data %h want 1/11111111", hreadyout0, hrdata0); end
        tick();
    endtask

    task automatic test_no_accept();
        hready_en = 1'b0;
        addr_phase(1'b1, 1'b0, 1'b1, 3'd2, 32'h20);
        tick();
        hready_en = 1'b1; bus_idle();
        @(negedge hclk);
        n_tests++; if ({hreadyout0, mem_ce0} !== 2'b10) begin n_fail++; $display("FAIL hready_low: got ro/ce %b want 10", {hreadyout0, mem_ce0}); end
        addr_phase(1'b1, 1'b0, 1'b1, 3'd2, 32'h20); htrans = 2'b01;
        tick();
        bus_idle();
        @(negedge hclk);
        n_tests++; if ({hreadyout0, mem_ce0} !== 2'b10) begin n_fail++; $display("FAIL busy: got ro/ce %b want 10", {hreadyout0, mem_ce0}); end
        addr_phase(1'b0, 1'b0, 1'b0, 3'd2, 32'h20);
        tick();
        bus_idle();
        @(negedge hclk);
        n_tests++; if ({hreadyout0, mem_ce0} !== 2'b10) begin n_fail++; $display("FAIL unselected: got ro/ce %b want 10", {hreadyout0, mem_ce0}); end
    endtask

    task automatic test_wait_states();
        int lowc;
        int base;
        addr_phase(1'b0, 1'b1, 1'b1, 3'd2, 32'h20);
        tick();
        bus_idle(); hwdata = 32'h12345678; hwstrb = 4'hF;
        lowc = 0;
        @(negedge hclk);
        while (hreadyout1 !== 1'b1 && lowc < 10) begin lowc++; tick(); @(negedge hclk); end
        n_tests++; if (lowc !== 3) begin n_fail++; $display("FAIL ws_wr_lowcycles: got %0d want 3", lowc); end
        n_tests++; if ({mem_ce1, mem_we1} !== 2'b11 || mem_be1 !== 4'hF || mem_addr1 !== 10'd8) begin n_fail++; $display("FAIL ws_wr_strobe: got ce/we %b be %h addr %0d want 11/f/8", {mem_ce1, mem_we1}, mem_be1, mem_addr1); end
        tick();
        base = ce_cnt1;
        addr_phase(1'b0, 1'b1, 1'b0, 3'd2, 32'h20);
        tick();
        bus_idle();
        lowc = 0;
        @(negedge hclk);
        while (hreadyout1 !== 1'b1 && lowc < 10) begin lowc++; tick(); @(negedge hclk); end
        n_tests++; if (lowc !== 4) begin n_fail++; $display("FAIL ws_rd_lowcycles: got %0d want 4", lowc); end
        n_tests++; if (hrdata1 !== 32'h12345678 || hresp1 !== 1'b0) begin n_fail++; $display("FAIL ws_rd_data: got %h rsp %b want 12345678/0", hrdata1, hresp1); end
        n_tests++; if (ce_cnt1 - base !== 1) begin n_fail++; $display("FAIL ws_ce_pulses: got %0d want 1", ce_cnt1 - base); end
        tick();
    endtask

    task automatic test_reset_mid();
        int lowc;
        addr_phase(1'b1, 1'b1, 1'b0, 3'd2, 32'h10);
        tick();
        bus_idle();
        @(negedge hclk);
        n_tests++; if ({hreadyout0, mem_ce0, hreadyout1} !== 3'b010) begin n_fail++; $display("FAIL mid_pre: got ro0/ce0/ro1 %b want 010", {hreadyout0, mem_ce0, hreadyout1}); end
        hresetn = 1'b0;
        #1;
        n_tests++; if ({hreadyout0, mem_ce0, hreadyout1, mem_ce1} !== 4'b1010) begin n_fail++; $display("FAIL mid_rst: got ro0/ce0/ro1/ce1 %b want 1010", {hreadyout0, mem_ce0, hreadyout1, mem_ce1}); end
        n_tests++; if (hrdata0 !== 32'h0) begin n_fail++; $display("FAIL mid_rst_hrdata: got %h want 0", hrdata0); end
        tick();
        hresetn = 1'b1;
        addr_phase(1'b1, 1'b0, 1'b0, 3'd2, 32'h10);
        tick();
        bus_idle();
        tick();
        @(negedge hclk);
        n_tests++; if (hreadyout0 !== 1'b1 || hrdata0 !== 32'h1234BEEF) begin n_fail++; $display("FAIL post_rst_rd0: got ro %b data %h want 1/1234beef", hreadyout0, hrdata0); end
        tick();
        addr_phase(1'b0, 1'b1, 1'b0, 3'd2, 32'h20);
        tick();
        bus_idle();
        lowc = 0;
        @(negedge hclk);
        while (hreadyout1 !== 1'b1 && lowc < 10) begin lowc++; tick(); @(negedge hclk); end
        n_tests++; if (lowc !== 4 || hrdata1 !== 32'h12345678) begin n_fail++; $display("FAIL post_rst_rd1: got low %0d data %h want 4/12345678", lowc, hrdata1); end
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        hresetn = 1'b0; hready_en = 1'b1; hwdata = '0; hwstrb = '0;
        bus_idle();
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_errors();
        test_back_to_back();
        test_no_accept();
        test_wait_states();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
